// File: rtl/present_pkg.sv
// PRESENT-80 constants and pure round helpers shared by the round stages.
package present_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 80;

  // Nibble n of the table is SBOX(n).
  localparam logic [15:0][3:0] SBOX = {
    4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
    4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC
  };

  function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = SBOX[s[4*n +: 4]];
    return o;
  endfunction

  function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) o[(16*i) % 63] = s[i];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       round);
    logic [KEY_W-1:0] o;
    o          = {k[18:0], k[79:19]};
    o[79:76]   = SBOX[o[79:76]];
    o[19:15]   = o[19:15] ^ round;
    return o;
  endfunction

endpackage

// File: rtl/present_round.sv
// One PRESENT-80 round: combinational round function plus its pipeline register.
module present_round
  import present_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BLK_W-1:0] i_state,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_valid,
  output logic [BLK_W-1:0] o_state,
  output logic [KEY_W-1:0] o_key,
  output logic             o_valid
);

  logic [BLK_W-1:0] w_state;
  logic [KEY_W-1:0] w_key;

  assign w_state = p_layer(sbox_layer(i_state ^ i_key[79:16]));
  assign w_key   = key_update(i_key, 5'(ROUND));

  // Data loads every cycle; valid only qualifies it downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_state <= '0;
      o_key   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_state <= w_state;
      o_key   <= w_key;
      o_valid <= i_valid;
    end
  end

endmodule

// File: rtl/present_cipher.sv
// Fully pipelined PRESENT-80 encryptor, one round per stage, one block per clock.
// PRESENT_IN_REG_EN adds an input register stage (latency NUM_ROUNDS+2).
module present_cipher
  import present_pkg::*;
#(
  parameter int NUM_ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [BLK_W-1:0] plaintext,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  output logic [BLK_W-1:0] ciphertext
);

  logic [NUM_ROUNDS:0][BLK_W-1:0] w_state;
  logic [NUM_ROUNDS:0][KEY_W-1:0] w_key;
  logic [NUM_ROUNDS:0]            w_vld_pipe;
  logic [BLK_W-1:0]               r_ct;
  logic                           r_ov;

`ifdef PRESENT_IN_REG_EN
  logic [BLK_W-1:0] r_pt;
  logic [KEY_W-1:0] r_key;
  logic             r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pt  <= '0;
      r_key <= '0;
      r_vld <= 1'b0;
    end else begin
      r_pt  <= plaintext;
      r_key <= key;
      r_vld <= in_valid;
    end
  end

  assign w_state[0]    = r_pt;
  assign w_key[0]      = r_key;
  assign w_vld_pipe[0] = r_vld;
`else
  assign w_state[0]    = plaintext;
  assign w_key[0]      = key;
  assign w_vld_pipe[0] = in_valid;
`endif

  for (genvar g = 1; g <= NUM_ROUNDS; g++) begin : g_round
    present_round #(.ROUND(g)) u_round (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_state (w_state[g-1]),
      .i_key   (w_key[g-1]),
      .i_valid (w_vld_pipe[g-1]),
      .o_state (w_state[g]),
      .o_key   (w_key[g]),
      .o_valid (w_vld_pipe[g])
    );
  end

  // Final key whitening into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ct <= '0;
      r_ov <= 1'b0;
    end else begin
      r_ct <= w_state[NUM_ROUNDS] ^ w_key[NUM_ROUNDS][79:16];
      r_ov <= w_vld_pipe[NUM_ROUNDS];
    end
  end

  assign ciphertext = r_ct;
  assign out_valid  = r_ov;

endmodule

// File: tb/tb_present_cipher.sv
// Scoreboard bench for present_cipher: known vectors, back-to-back, reset flush.
module tb_present_cipher;

`ifdef PRESENT_IN_REG_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] plaintext = '0;
  logic [79:0] key = '0;
  logic        out_valid;
  logic [63:0] ciphertext;

  present_cipher #(.NUM_ROUNDS(31)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] ct; int due; } exp_t;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // Straight-line software PRESENT-80 reference.
  function automatic logic [63:0] model(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s, t;
    logic [79:0] kk;
    logic [4:0]  rc;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
      s = '0;
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16*i) % 63] = t[i];
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = SB[kk[79:76]];
      rc = 5'(r);
      kk[19:15] = kk[19:15] ^ rc;
    end
    return s ^ kk[79:16];
  endfunction

  always @(posedge clk) cyc++;

  // Every checked cycle: out_valid must match the scoreboard head exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (q.size() != 0 && q[0].due == cyc) begin
        if (out_valid !== 1'b1 || ciphertext !== q[0].ct) begin
          bad++;
          $display("FAIL scoreboard cyc=%0d got v=%b ct=%h want v=1 ct=%h",
                   cyc, out_valid, ciphertext, q[0].ct);
        end
        void'(q.pop_front());
      end else if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL spurious_valid cyc=%0d got v=%b want v=0", cyc, out_valid);
      end
    end
  end

  task automatic send(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp_ct);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    plaintext = pt;
    key       = k;
    e.ct  = exp_ct;
    e.due = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid  = 1'b0;
    plaintext = $urandom;
    key       = {$urandom, $urandom, 16'($urandom)};
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout pending=%0d want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 2;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got %b want 0", out_valid);
    end
    if (ciphertext !== 64'h0) begin
      bad++; $display("FAIL reset_ct got %h want 0", ciphertext);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_vectors();
    send(64'h0, 80'h0, 64'h5579C1387B228445);
    idle();
    drain("kv_zero");
    send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
    idle();
    drain("kv_key_ones");
    send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
    idle();
    drain("kv_pt_ones");
    send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);
    idle();
    drain("kv_all_ones");
  endtask

  task automatic test_back_to_back();
    logic [63:0] pt;
    logic [79:0] k;
    send(64'h0, 80'h0, 64'h5579C1387B228445);
    send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);
    send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
    send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
    idle();
    drain("b2b_known");
    send(64'hAABBCCDDAABBCCDD, 80'hAABBCCDDAABBCCDDCCDD,
         model(64'hAABBCCDDAABBCCDD, 80'hAABBCCDDAABBCCDDCCDD));
    for (int i = 0; i < 6; i++) begin
      pt = {$urandom, $urandom};
      k  = {$urandom, $urandom, 16'($urandom)};
      send(pt, k, model(pt, k));
    end
    idle();
    drain("b2b_model");
  endtask

  task automatic test_reset_flush();
    int first_due;
    logic [63:0] pt;
    logic [79:0] k;
    for (int i = 0; i < 10; i++) begin
      pt = {$urandom, $urandom};
      k  = {$urandom, $urandom, 16'($urandom)};
      send(pt, k, model(pt, k));
      if (i == 0) first_due = q[q.size()-1].due;
    end
    idle();
    while (cyc < first_due + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    total += 2;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_valid got %b want 0", out_valid);
    end
    if (ciphertext !== 64'h0) begin
      bad++; $display("FAIL flush_ct got %h want 0", ciphertext);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send(64'h0, 80'h0, 64'h5579C1387B228445);
    idle();
    drain("after_flush");
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_reset_flush();
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
